// File: rtl/proc_op_scheduler.sv
// Two-requester scheduler sharing one fixed-latency processor datapath.
// Define PROC_SCHED_RR_EN for round-robin tie-breaking; otherwise requester 0 wins ties.
module proc_op_scheduler #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_data,
  input  logic [63:0] req_imm,
  input  logic [1:0]  req_sel,
  input  logic [31:0] req_flags,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_data,
  output logic [7:0]  rsp_status,
  output logic [31:0] proc_data_in,
  output logic [31:0] proc_i_data,
  output logic        proc_data_select,
  output logic [15:0] proc_status_flags,
  input  logic [31:0] proc_data_out,
  input  logic [7:0]  proc_status,
  output logic        busy,
  output logic        grant_id
);

  if ((LATENCY < 1) || (LATENCY > 15)) begin : g_latency_check
    $error("proc_op_scheduler: LATENCY must be in 1..15");
  end

  localparam logic [3:0] LAT4 = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       win;
  logic       hs;
  logic       rsp_go;

`ifdef PROC_SCHED_RR_EN
  logic ptr;

  // A tie goes to the pointer; a lone requester wins outright.
  always_comb begin
    if (req_valid == 2'b11) win = ptr;
    else                    win = req_valid[1] & ~req_valid[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         ptr <= 1'b0;
    else if (rsp_go) ptr <= ~grant_id;
  end
`else
  always_comb win = ~req_valid[0];
`endif

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    req_ready = 2'b00;
    if ((state == S_IDLE) && (req_valid != 2'b00)) req_ready[win] = 1'b1;
  end

  assign hs     = |(req_valid & req_ready);
  assign rsp_go = (state == S_RESP) && rsp_ready[grant_id];
  assign busy   = (state != S_IDLE);

  always_comb begin
    rsp_valid = 2'b00;
    if (state == S_RESP) rsp_valid[grant_id] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (hs)             state_nxt = S_WAIT;
      S_WAIT:  if (cnt == 4'd1)    state_nxt = S_RESP;
      S_RESP:  if (rsp_go)         state_nxt = S_IDLE;
      default:                     state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt               <= 4'd0;
      grant_id          <= 1'b0;
      rsp_data          <= 32'd0;
      rsp_status        <= 8'd0;
      proc_data_in      <= 32'd0;
      proc_i_data       <= 32'd0;
      proc_data_select  <= 1'b0;
      proc_status_flags <= 16'd0;
    end else begin
      if (hs) begin
        proc_data_in      <= req_data[{win, 5'd0} +: 32];
        proc_i_data       <= req_imm[{win, 5'd0} +: 32];
        proc_data_select  <= req_sel[win];
        proc_status_flags <= req_flags[{win, 4'd0} +: 16];
        grant_id          <= win;
        cnt               <= LAT4;
      end
      // The result is sampled on the edge after the counter reaches 1.
      if (state == S_WAIT) begin
        if (cnt == 4'd1) begin
          rsp_data   <= proc_data_out;
          rsp_status <= proc_status;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_proc_op_scheduler.sv
// Scoreboarded bench: three schedulers (LATENCY 2, 1, 15) share stimulus, each with a
// windowed processor model that only presents the correct result on the sampling edge.
module tb_proc_op_scheduler;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic [7:0]  status;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [63:0] req_data;
  logic [63:0] req_imm;
  logic [1:0]  req_sel;
  logic [31:0] req_flags;
  logic [1:0]  rsp_ready;

  logic [1:0]  req_ready         [3];
  logic [1:0]  rsp_valid         [3];
  logic [31:0] rsp_data          [3];
  logic [7:0]  rsp_status        [3];
  logic [31:0] proc_data_in      [3];
  logic [31:0] proc_i_data       [3];
  logic        proc_data_select  [3];
  logic [15:0] proc_status_flags [3];
  logic        busy              [3];
  logic        grant_id          [3];

  exp_t exp_q[3][$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int L = (k == 0) ? 2 : ((k == 1) ? 1 : 15);
    logic [31:0] pdo;
    logic [7:0]  pst;
    int          mcnt;
    int          since;
    logic [1:0]  prev_v = 2'b00;
    exp_t        e;

    proc_op_scheduler #(.LATENCY(L)) dut (
      .clk               (clk),
      .rst               (rst),
      .req_valid         (req_valid),
      .req_ready         (req_ready[k]),
      .req_data          (req_data),
      .req_imm           (req_imm),
      .req_sel           (req_sel),
      .req_flags         (req_flags),
      .rsp_valid         (rsp_valid[k]),
      .rsp_ready         (rsp_ready),
      .rsp_data          (rsp_data[k]),
      .rsp_status        (rsp_status[k]),
      .proc_data_in      (proc_data_in[k]),
      .proc_i_data       (proc_i_data[k]),
      .proc_data_select  (proc_data_select[k]),
      .proc_status_flags (proc_status_flags[k]),
      .proc_data_out     (pdo),
      .proc_status       (pst),
      .busy              (busy[k]),
      .grant_id          (grant_id[k])
    );

    // Processor model: result valid only in the cycle ending at handshake + L.
    always_comb begin
      pdo = 32'hDEAD_BEEF;
      pst = 8'hEE;
      if (mcnt == 1) begin
        pdo = proc_data_select[k] ? proc_data_in[k] + proc_i_data[k]
                                  : proc_data_in[k] - proc_i_data[k];
        pst = proc_status_flags[k][7:0] + 8'h03;
      end
    end

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        mcnt  <= 0;
        since <= 0;
      end else begin
        if (mcnt != 0) mcnt <= mcnt - 1;
        since <= since + 1;
        if ((req_valid & req_ready[k]) != 2'b00) begin
          mcnt  <= L;
          since <= 0;
        end
      end
    end

    // Monitor: latency of every rising response and scoreboard pop on each response handshake.
    always @(negedge clk) begin
      #2;
      if (!rst) begin
        if ((rsp_valid[k] != 2'b00) && (prev_v == 2'b00))
          check($sformatf("latency_L%0d", L), since, L);
        if ((rsp_valid[k] & rsp_ready) != 2'b00) begin
          if (exp_q[k].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp_L%0d: got rsp_valid %b expected none", L, rsp_valid[k]);
          end else begin
            e = exp_q[k].pop_front();
            check($sformatf("rsp_id_L%0d", L), {31'd0, rsp_valid[k][1]}, {31'd0, e.id});
            check($sformatf("rsp_data_L%0d", L), rsp_data[k], e.data);
            check($sformatf("rsp_status_L%0d", L), {24'd0, rsp_status[k]}, {24'd0, e.status});
          end
        end
      end
      prev_v = rsp_valid[k];
    end
  end

  task automatic push_all(input exp_t e);
    for (int k = 0; k < 3; k++) exp_q[k].push_back(e);
  endtask

  task automatic check_reset_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s_busy%0d", tag, k), {31'd0, busy[k]}, 32'd0);
      check($sformatf("%s_grant%0d", tag, k), {31'd0, grant_id[k]}, 32'd0);
      check($sformatf("%s_rsp_valid%0d", tag, k), {30'd0, rsp_valid[k]}, 32'd0);
      check($sformatf("%s_rsp_data%0d", tag, k), rsp_data[k], 32'd0);
      check($sformatf("%s_rsp_status%0d", tag, k), {24'd0, rsp_status[k]}, 32'd0);
      check($sformatf("%s_pdin%0d", tag, k), proc_data_in[k], 32'd0);
      check($sformatf("%s_pimm%0d", tag, k), proc_i_data[k], 32'd0);
      check($sformatf("%s_psel%0d", tag, k), {31'd0, proc_data_select[k]}, 32'd0);
      check($sformatf("%s_pflags%0d", tag, k), {16'd0, proc_status_flags[k]}, 32'd0);
    end
  endtask

  task automatic wait_all_rsp();
    int n = 0;
    while (n < 40 && !(rsp_valid[0] != 2'b00 && rsp_valid[1] != 2'b00 && rsp_valid[2] != 2'b00)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: got no response within %0d cycles", n);
    end
  endtask

  task automatic wait_all_idle();
    int n = 0;
    while (n < 40 && (busy[0] || busy[1] || busy[2])) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got busy after %0d cycles", n);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic gseq [3];
`ifdef PROC_SCHED_RR_EN
    gseq = '{1'b0, 1'b1, 1'b0};
`else
    gseq = '{1'b0, 1'b0, 1'b0};
`endif
    rst = 1'b1; req_valid = 2'b00; req_data = '0; req_imm = '0;
    req_sel = 2'b00; req_flags = '0; rsp_ready = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_all("por");
    for (int k = 0; k < 3; k++) check($sformatf("por_req_ready%0d", k), {30'd0, req_ready[k]}, 32'd0);

    // Single op from requester 0, then backpressure with the non-granted ready high.
    @(negedge clk);
    req_data[31:0] = 32'h0000_0005; req_imm[31:0] = 32'h0000_0003;
    req_sel[0] = 1'b1; req_flags[15:0] = 16'h0001; req_valid = 2'b01;
    push_all('{1'b0, 32'h0000_0008, 8'h04});
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("single_req_ready%0d", k), {30'd0, req_ready[k]}, 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("single_pdin%0d", k), proc_data_in[k], 32'h5);
      check($sformatf("single_pimm%0d", k), proc_i_data[k], 32'h3);
      check($sformatf("single_psel%0d", k), {31'd0, proc_data_select[k]}, 32'd1);
      check($sformatf("single_pflags%0d", k), {16'd0, proc_status_flags[k]}, 32'h1);
      check($sformatf("single_busy%0d", k), {31'd0, busy[k]}, 32'd1);
      check($sformatf("single_grant%0d", k), {31'd0, grant_id[k]}, 32'd0);
    end
    wait_all_rsp();
    req_valid = 2'b10; rsp_ready = 2'b10;
    repeat (5) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check($sformatf("bp_data%0d", k), rsp_data[k], 32'h8);
        check($sformatf("bp_status%0d", k), {24'd0, rsp_status[k]}, 32'h04);
        check($sformatf("bp_req_ready%0d", k), {30'd0, req_ready[k]}, 32'd0);
        check($sformatf("bp_rsp_valid%0d", k), {30'd0, rsp_valid[k]}, 32'd1);
      end
    end
    req_valid = 2'b00; rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("release_busy%0d", k), {31'd0, busy[k]}, 32'd0);
      check($sformatf("release_rsp_valid%0d", k), {30'd0, rsp_valid[k]}, 32'd0);
    end

    // Abort: reset pulse while every scheduler is in WAIT.
    @(negedge clk);
    req_data[31:0] = 32'h7; req_imm[31:0] = 32'h2; req_sel[0] = 1'b0;
    req_flags[15:0] = 16'h0002; req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    for (int k = 0; k < 3; k++) check($sformatf("abort_busy%0d", k), {31'd0, busy[k]}, 32'd1);
    #3 rst = 1'b1;
    #1 check_reset_all("abort");
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    for (int k = 0; k < 3; k++) check($sformatf("abort_no_rsp%0d", k), {30'd0, rsp_valid[k]}, 32'd0);

    // Follow-up op from requester 1 alone.
    req_data[63:32] = 32'h50; req_imm[63:32] = 32'h8; req_sel[1] = 1'b1;
    req_flags[31:16] = 16'h0040; rsp_ready = 2'b11; req_valid = 2'b10;
    push_all('{1'b1, 32'h0000_0058, 8'h43});
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("lone1_req_ready%0d", k), {30'd0, req_ready[k]}, 32'd2);
    @(negedge clk);
    req_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("lone1_grant%0d", k), {31'd0, grant_id[k]}, 32'd1);
      check($sformatf("lone1_pdin%0d", k), proc_data_in[k], 32'h50);
    end
    wait_all_idle();

    // Tie held for three back-to-back ops.
    rsp_ready = 2'b00;
    req_data = {32'h0000_0100, 32'h0000_000A};
    req_imm  = {32'h0000_0023, 32'h0000_0004};
    req_sel  = 2'b10;
    req_flags = {16'h0020, 16'h0010};
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      if (gseq[i]) push_all('{1'b1, 32'h0000_0123, 8'h23});
      else         push_all('{1'b0, 32'h0000_0006, 8'h13});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check($sformatf("tie%0d_grant%0d", i, k), {31'd0, grant_id[k]}, {31'd0, gseq[i]});
        check($sformatf("tie%0d_busy%0d", i, k), {31'd0, busy[k]}, 32'd1);
        check($sformatf("tie%0d_req_ready%0d", i, k), {30'd0, req_ready[k]}, 32'd0);
      end
      wait_all_rsp();
      rsp_ready = 2'b11;
      @(negedge clk);
      rsp_ready = 2'b00;
    end
    req_valid = 2'b00;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("end_busy%0d", k), {31'd0, busy[k]}, 32'd0);
      check($sformatf("end_queue%0d", k), exp_q[k].size(), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
